// File: rtl/riscy_pkg.sv
// rtl/riscy_pkg.sv - shared RV32I decode constants and helpers
package riscy_pkg;

  // Major opcodes handled by the decode stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // funct7 values that select the base or alternate ALU behaviour
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // ALU operation select carried in funct3
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  // Only register-register ops read rs2 from the register file
  function automatic logic op_uses_rs2(input logic [6:0] opcode);
    return opcode == OPC_OP;
  endfunction

  // Encoding check for the OP and OP-IMM subsets this stage supports
  function automatic logic is_legal(input logic [31:0] instr);
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    opcode = instr[6:0];
    f3     = instr[14:12];
    f7     = instr[31:25];
    ok     = 1'b0;
    if (opcode == OPC_OP) begin
      ok = (f7 == F7_BASE) ||
           ((f7 == F7_ALT) && ((f3 == ALU_ADD) || (f3 == ALU_SR)));
    end else if (opcode == OPC_OP_IMM) begin
      if (f3 == ALU_SLL) begin
        ok = (f7 == F7_BASE);
      end else if (f3 == ALU_SR) begin
        ok = (f7 == F7_BASE) || (f7 == F7_ALT);
      end else begin
        ok = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch, writeback and ALU handshake bundle
interface decode_stage_if #(
  parameter int XLEN = 32
);
  // Fetch side
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  // Writeback side
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  // ALU side
  logic            alu_valid;
  logic            alu_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_addr;
  logic            illegal;

  // Environment driving fetch/writeback and acting as the ALU
  modport master (
    output instr_valid, instr, wb_en, wb_addr, wb_data, alu_ready,
    input  instr_ready, alu_valid, rs1, rs2, funct3, funct7, rd_addr, illegal
  );

  // The decode stage itself
  modport slave (
    input  instr_valid, instr, wb_en, wb_addr, wb_data, alu_ready,
    output instr_ready, alu_valid, rs1, rs2, funct3, funct7, rd_addr, illegal
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// rtl/decode_stage_regfile.sv - 2R1W register file with x0 tied to zero
module decode_stage_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Synchronous write port; x0 is never written so it stays zero after clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read ports; x0 forced to zero independent of storage
  always_comb begin
    rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I OP/OP-IMM decode and operand fetch ahead of the ALU
module decode_stage
  import riscy_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave bus
);

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd_f;
  logic [2:0] f3;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [6:0] f7;

  assign opcode = bus.instr[6:0];
  assign rd_f   = bus.instr[11:7];
  assign f3     = bus.instr[14:12];
  assign rs1_f  = bus.instr[19:15];
  assign rs2_f  = bus.instr[24:20];
  assign f7     = bus.instr[31:25];

  // Registered ALU-side state and scoreboard
  logic            alu_valid_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic [4:0]      rd_q;
  logic            illegal_q;
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Decode results
  logic            legal;
  logic            uses_rs2;
  logic            rs1_bypass;
  logic            rs2_bypass;
  logic            hazard;
  logic            accept;
  logic            issue;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] imm_sext;
  logic [6:0]      f7_out;

  decode_stage_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (5)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (bus.wb_en),
    .waddr_i  (bus.wb_addr),
    .wdata_i  (bus.wb_data),
    .raddr1_i (rs1_f),
    .rdata1_o (rf_rd1),
    .raddr2_i (rs2_f),
    .rdata2_o (rf_rd2)
  );

  // Hazard detection and same-cycle writeback bypass of source operands
  always_comb begin
    legal      = is_legal(bus.instr);
    uses_rs2   = op_uses_rs2(opcode);
    rs1_bypass = bus.wb_en && (bus.wb_addr == rs1_f) && (rs1_f != 5'd0);
    rs2_bypass = bus.wb_en && (bus.wb_addr == rs2_f) && (rs2_f != 5'd0);
    // busy_q[0] is never set, so x0 sources never stall
    hazard     = (busy_q[rs1_f] && !rs1_bypass) ||
                 (uses_rs2 && busy_q[rs2_f] && !rs2_bypass);
    accept     = bus.instr_valid && bus.instr_ready;
    issue      = accept && legal;
    imm_sext   = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    op_a       = rs1_bypass ? bus.wb_data : rf_rd1;
    if (uses_rs2) begin
      op_b = rs2_bypass ? bus.wb_data : rf_rd2;
    end else begin
      op_b = imm_sext;
    end
    // Immediate forms only carry a modifier for shift-right
    if (uses_rs2 || (f3 == ALU_SR)) begin
      f7_out = f7;
    end else begin
      f7_out = F7_BASE;
    end
  end

  // Accept whenever the output slot frees up this cycle and no source is pending
  assign bus.instr_ready = (!alu_valid_q || bus.alu_ready) && !hazard;

  // Scoreboard next state: writeback clears first so a same-cycle issue wins
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_en) begin
      busy_d[bus.wb_addr] = 1'b0;
    end
    if (issue && (rd_f != 5'd0)) begin
      busy_d[rd_f] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // ALU output register: load on issue, drop valid once the ALU takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= accept && !legal;
      if (issue) begin
        alu_valid_q <= 1'b1;
        rs1_q       <= op_a;
        rs2_q       <= op_b;
        funct3_q    <= f3;
        funct7_q    <= f7_out;
        rd_q        <= rd_f;
      end else if (bus.alu_ready) begin
        alu_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_valid = alu_valid_q;
  assign bus.rs1       = rs1_q;
  assign bus.rs2       = rs2_q;
  assign bus.funct3    = funct3_q;
  assign bus.funct7    = funct7_q;
  assign bus.rd_addr   = rd_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage with a reference model
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus();

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
  } exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  exp_t       aluq[$];
  int         illq[$];
  logic [4:0] pend[$];

  logic [31:0] mreg [32];
  bit          mbusy [32];
  bit          mvalid;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = 32'h0;
      mbusy[i] = 1'b0;
    end
    mvalid = 1'b0;
    aluq.delete();
    illq.delete();
    pend.delete();
  endtask

  // Architectural legality of RV32I OP / OP-IMM
  function automatic bit ref_legal(input logic [31:0] i);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    op = i[6:0];
    f7 = i[31:25];
    f3 = i[14:12];
    if (op == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (op == 7'h13) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return mreg[a];
  endfunction

  function automatic bit ref_stall(input logic [4:0] a, input bit we, input logic [4:0] wa);
    return (a != 5'd0) && mbusy[a] && !(we && wa == a);
  endfunction

  // One cycle of stimulus; expectations come from the model state before the edge
  task automatic drive(input bit v, input logic [31:0] ins, input bit ar,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd);
    bit   haz;
    bit   rdy;
    bit   iss;
    exp_t e;
    @(posedge clk);
    #2;
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.alu_ready   = ar;
    bus.wb_en       = we;
    bus.wb_addr     = wa;
    bus.wb_data     = wd;
    #1;
    haz = ref_stall(ins[19:15], we, wa) ||
          (ins[6:0] == 7'h33 && ref_stall(ins[24:20], we, wa));
    rdy = (!mvalid || ar) && !haz;
    check("instr_ready", {31'b0, bus.instr_ready}, {31'b0, rdy});
    iss = v && rdy && ref_legal(ins);
    if (iss) begin
      e.c  = cyc + 1;
      e.a  = ref_read(ins[19:15], we, wa, wd);
      e.b  = (ins[6:0] == 7'h33) ? ref_read(ins[24:20], we, wa, wd)
                                 : {{20{ins[31]}}, ins[31:20]};
      e.f3 = ins[14:12];
      e.f7 = (ins[6:0] == 7'h33 || ins[14:12] == 3'd5) ? ins[31:25] : 7'h00;
      e.rd = ins[11:7];
      aluq.push_back(e);
    end else if (v && rdy) begin
      illq.push_back(cyc + 1);
    end
    if (mvalid && ar) mvalid = 1'b0;
    if (we && wa != 5'd0) begin
      mreg[wa]  = wd;
      mbusy[wa] = 1'b0;
    end
    if (iss) begin
      mvalid = 1'b1;
      if (ins[11:7] != 5'd0) begin
        mbusy[ins[11:7]] = 1'b1;
        pend.push_back(ins[11:7]);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.wb_en = 1'b0;
    #1;
    check("rst_alu_valid", {31'b0, bus.alu_valid}, 32'h0);
    check("rst_illegal", {31'b0, bus.illegal}, 32'h0);
    check("rst_rs1", bus.rs1, 32'h0);
    check("rst_rs2", bus.rs2, 32'h0);
    check("rst_funct3", {29'b0, bus.funct3}, 32'h0);
    check("rst_funct7", {25'b0, bus.funct7}, 32'h0);
    check("rst_rd_addr", {27'b0, bus.rd_addr}, 32'h0);
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] gen_instr();
    int          k;
    int          s;
    logic [4:0]  rd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    k   = $urandom_range(0, 9);
    s   = $urandom_range(0, 3);
    rd  = 5'($urandom_range(0, 7));
    r1  = 5'($urandom_range(0, 7));
    r2  = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    f7  = (s == 0) ? 7'h20 : (s == 1) ? 7'($urandom) : 7'h00;
    if (k < 4) return {f7, r2, r1, f3, rd, 7'h33};
    if (k < 8) begin
      if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = f7;
      return {imm, r1, f3, rd, 7'h13};
    end
    if (k == 8) return {imm, r1, f3, rd, 7'h03};
    return 32'h00000073;
  endfunction

  // Monitor: compares DUT outputs against the expected queues every cycle
  exp_t mon_e;
  bit   mon_expi;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      while (illq.size() > 0 && illq[0] < cyc) begin
        void'(illq.pop_front());
        total++;
        bad++;
        $display("FAIL illegal_missed got=0 want=1");
      end
      mon_expi = (illq.size() > 0) && (illq[0] == cyc);
      if (mon_expi) void'(illq.pop_front());
      check("illegal", {31'b0, bus.illegal}, {31'b0, mon_expi});
      if (bus.alu_valid) begin
        if (aluq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL alu_unexpected got=valid want=idle");
        end else begin
          mon_e = aluq[0];
          check("rs1", bus.rs1, mon_e.a);
          check("rs2", bus.rs2, mon_e.b);
          check("funct3", {29'b0, bus.funct3}, {29'b0, mon_e.f3});
          check("funct7", {25'b0, bus.funct7}, {25'b0, mon_e.f7});
          check("rd_addr", {27'b0, bus.rd_addr}, {27'b0, mon_e.rd});
          if (bus.alu_ready) void'(aluq.pop_front());
        end
      end else if (aluq.size() > 0 && aluq[0].c <= cyc) begin
        void'(aluq.pop_front());
        total++;
        bad++;
        $display("FAIL alu_missing got=idle want=valid");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          v;
    bit          ar;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.alu_ready   = 1'b1;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = 5'd0;
    bus.wb_data     = 32'h0;
    model_clear();
    do_reset();
    mon_en = 1'b1;

    drive(1, 32'h01400093, 1, 0, 5'd0, 32'h0);        // ADDI x1,x0,20
    drive(1, 32'h002081B3, 1, 0, 5'd0, 32'h0);        // ADD x3,x1,x2 stalls
    drive(1, 32'h002081B3, 1, 1, 5'd1, 32'd20);       // same, bypass x1
    drive(0, 32'h0, 1, 1, 5'd6, 32'd8);
    drive(0, 32'h0, 1, 1, 5'd7, 32'd3);
    drive(1, 32'h407302B3, 1, 1, 5'd3, 32'h0);        // SUB x5,x6,x7
    drive(1, 32'hFFF00093, 1, 0, 5'd0, 32'h0);        // ADDI x1,x0,-1
    drive(1, 32'h4030D113, 1, 1, 5'd1, 32'hFFFFFFFF); // SRAI x2,x1,3
    drive(0, 32'h0, 1, 1, 5'd5, 32'h0);
    drive(0, 32'h0, 1, 1, 5'd2, 32'h0);
    drive(1, 32'h00500213, 1, 0, 5'd0, 32'h0);        // ADDI x4,x0,5
    repeat (3) drive(1, 32'h00100293, 0, 0, 5'd0, 32'h0);
    do_reset();                                       // mid-stall reset
    drive(1, 32'h00020313, 1, 0, 5'd0, 32'h0);        // ADDI x6,x4,0
    drive(1, 32'h00000073, 1, 0, 5'd0, 32'h0);        // ECALL
    drive(1, 32'h022081B3, 1, 0, 5'd0, 32'h0);        // MUL
    drive(1, 32'h000183B3, 1, 1, 5'd6, 32'h0);        // ADD x7,x3,x0
    drive(0, 32'h0, 1, 1, 5'd7, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(0, 4) != 0);
      ar = ($urandom_range(0, 3) != 0);
      wd = $urandom;
      we = 1'b0;
      wa = 5'd0;
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        we = 1'b1;
        wa = pend.pop_front();
      end else if ($urandom_range(0, 7) == 0) begin
        we = 1'b1;
        wa = 5'($urandom_range(0, 7));
      end
      drive(v, gen_instr(), ar, we, wa, wd);
    end

    for (int n = 0; n < 40; n++) begin
      if (pend.size() > 0) drive(0, 32'h0, 1, 1, pend.pop_front(), $urandom);
      else drive(0, 32'h0, 1, 0, 5'd0, 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check("alu_queue_drained", aluq.size(), 32'h0);
    check("illegal_queue_drained", illq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU.
- Accepts one RV32I instruction per cycle from fetch and decodes OP and OP-IMM.
- Reads operands from an internal register file and presents rs1/rs2/funct3/funct7 to the ALU through a registered valid/ready interface.
- Tracks in-flight destination registers with a scoreboard, takes writeback from downstream, and stalls fetch on RAW hazards and ALU backpressure.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- instr_valid  in  1  fetch presents an instruction.
- instr  in  32  instruction word.
- instr_ready  out  1  stage accepts instr this cycle.
- wb_en  in  1  writeback strobe from downstream.
- wb_addr  in  5  writeback destination register.
- wb_data  in  XLEN  writeback value.
- alu_valid  out  1  operands to the ALU are valid.
- alu_ready  in  1  ALU consumes the operands this cycle.
- rs1  out  XLEN  operand A; connects to ALU rs1.
- rs2  out  XLEN  operand B: register value, or sign-extended immediate for OP-IMM; connects to ALU rs2.
- funct3  out  3  ALU operation select.
- funct7  out  7  ALU operation modifier, 7'h00 or 7'h20.
- rd_addr  out  5  destination register, travels with the operation.
- illegal  out  1  one-cycle pulse when an unsupported encoding is consumed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - alu_valid=0, illegal=0, rs1/rs2/funct3/funct7/rd_addr=0.
  - All registers and all scoreboard bits cleared.
  - An operation in flight is dropped. No output toggles until the first clk edge after rst_n rises.
- Handshakes:
  - Accept when instr_valid && instr_ready.
  - Transfer to the ALU when alu_valid && alu_ready.
  - While alu_valid && !alu_ready, all ALU-side outputs hold stable.
- instr_ready = (!alu_valid || alu_ready) && !hazard.
  - instr_ready is asserted combinationally even when instr_valid=0.
  - It is independent of instruction legality.
- Latency:
  - A legal instruction accepted in cycle N gives alu_valid=1 in cycle N+1.
  - Throughput is one instruction per cycle when there is no hazard and no backpressure.
- Legal encodings:
  - OP (0110011): funct7=00 with any funct3; funct7=20 with funct3 000 or 101.
  - OP-IMM (0010011):
    - funct3 001 requires instr[31:25]=00.
    - funct3 101 requires instr[31:25] of 00 or 20; that value is passed as funct7.
    - All other OP-IMM funct3 values: funct7 output forced to 00.
    - rs2 = sign-extended instr[31:20].
- Illegal encodings:
  - Any other encoding is consumed (instr_ready unaffected).
  - illegal=1 for the next cycle only.
  - No issue, no scoreboard change.
- Scoreboard, busy[NREGS-1:1]:
  - Issue with rd≠0 sets busy[rd].
  - wb_en clears busy[wb_addr].
  - Issue and writeback to the same register in the same cycle: set wins.
- Hazard: a used source register (rs1 always; rs2 for OP only) is busy and is not matched by a same-cycle wb_en to that address.
- Writeback:
  - Writes to x0 are ignored.
  - Same-cycle bypass: if wb_en && wb_addr equals a source register, the operand takes wb_data.
  - Register write occurs at the clock edge.
- Reads of x0 return 0 regardless of history.

Decomposition:
- Shared package riscy_pkg:
  - Opcode constants OPC_OP, OPC_OP_IMM.
  - funct3 enum alu_op_e (ADD, SLL, SLT, SLTU, XOR, SR, OR, AND).
  - Constants F7_BASE=7'h00, F7_ALT=7'h20.
- Sub-module regfile:
  - 2 asynchronous read ports, 1 synchronous write port.
  - x0 reads zero.
  - Asynchronous active-low clear.
  - Write bypass lives in decode_stage, not in regfile.

Test Plan:
- Reset, then ADDI x1,x0,20 (0x01400093), alu_ready=1 -> next cycle alu_valid=1, rs1=0, rs2=20, funct3=000, funct7=00, rd_addr=1; busy[1] set.
- ADD x3,x1,x2 (0x002081B3) issued right after the ADDI, no writeback -> instr_ready=0. Then wb_en x1=20 -> accepted that cycle, rs1=20 via bypass.
- Preload x6=8 and x7=3 via writeback, then SUB x5,x6,x7 (0x407302B3) -> rs1=8, rs2=3, funct7=20, funct3=000.
- ADDI x1,x0,-1 (0xFFF00093) -> rs2=0xFFFFFFFF. SRAI x2,x1,3 (0x4030D113) -> funct7=20, funct3=101, rs2[4:0]=3.
- Hold alu_ready=0 for 3 cycles with alu_valid=1 -> outputs stable and instr_ready=0. Assert rst_n low mid-stall -> alu_valid=0 immediately, busy cleared.
- ECALL (0x00000073) and MUL (0x022081B3) -> each consumed, illegal pulses for 1 cycle, alu_valid stays 0, scoreboard unchanged.
